ctrl_rega: RTL and testbench
============================

# ctrl_rega

Sequencing controller for one irrigation zone's watering timer. It owns a two-digit BCD down-counter (tens and units of minutes), presets it from the selected watering mode, decrements it on an external minute tick, and drives the valve. It supports pause (hold) and abort, and signals completion. It sits between the operator/sensor inputs and the valve driver. Its counter outputs feed the display decoders.

## Interface
Parameters:
- PRE_A, 8'h50: BCD preset, in minutes, loaded when Mode=0 (drip).
- PRE_B, 8'h30: BCD preset, in minutes, loaded when Mode=1 (sprinkler).

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request a watering cycle; sampled only in IDLE.
- Mode  in  1  preset select; sampled together with Start.
- Tick  in  1  one-cycle minute strobe; counts only in RUN.
- Hold  in  1  level input (soil-wet or low-tank sensor); pauses the cycle.
- Abort  in  1  level or pulse; cancels the cycle.
- Valve  out  1  valve open; high only in RUN.
- Busy  out  1  state is not IDLE.
- Paused  out  1  state is PAUSE.
- Done  out  1  one-cycle pulse when a cycle completes normally.
- Tens  out  4  BCD tens digit of the remaining time.
- Units  out  4  BCD units digit of the remaining time.

## Operation
- States: IDLE, LOAD, RUN, PAUSE, DONE.
- Reset: the controller enters IDLE. All outputs are 0 and Tens/Units are 0.
- Priority within a cycle is Reset > Abort > terminal count > Hold > Tick.
- IDLE:
  - On Start, capture Mode and go to LOAD.
  - Tick, Hold and Abort have no effect.
- LOAD:
  - Tens/Units are loaded with PRE_A or PRE_B according to the captured Mode.
  - If the loaded preset is 00, go to DONE; otherwise go to RUN.
  - A Tick in LOAD is dropped.
- RUN:
  - If the count is 00, go to DONE. This check happens before Hold.
  - Else if Hold=1, go to PAUSE with no decrement, even if Tick=1.
  - Else if Tick=1, decrement the count.
- Decrement rule:
  - If Units>0, Units decrements by 1.
  - If Units=0, Units becomes 9 and Tens decrements by 1.
  - The count never wraps below 00, because the 00 case exits before any decrement.
- PAUSE:
  - The count is frozen and Ticks are ignored.
  - When Hold=0, return to RUN.
- DONE:
  - Done=1 for exactly this one cycle.
  - The count stays at 00.
  - Go to IDLE on the next cycle.
- Abort in LOAD, RUN or PAUSE:
  - Go to IDLE next cycle and clear the count to 00.
  - Done is not pulsed.
- Abort in DONE has no effect, since DONE exits anyway.
- Start outside IDLE is ignored. Start is not queued.
- BCD digits hold only the values 0–9. Presets containing non-BCD nibbles are outside the contract.

## Timing
- Start high at edge N → LOAD at N+1 → RUN at N+2, with Valve=1 from N+2.
- Tick high in RUN at edge M → new count visible after M.
- From a preset of P minutes, Done is pulsed exactly 1 cycle after the cycle in which the count reaches 00, and then 1 cycle later Busy falls.
- The first Tick accepted in RUN counts a full minute; no partial-minute compensation is applied.
- Hold going high in RUN → PAUSE next cycle, so Valve falls 1 cycle after Hold.
- Hold going low → RUN next cycle, so Valve rises 1 cycle after Hold falls.
- Reset in any state → IDLE next cycle with all outputs 0. This is the same as an abort, but Done never pulses.

## Structure
- Shared include file ctrl_rega_defs.vh holds:
  - state encodings, 3-bit: IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4;
  - default preset constants.
- Sub-module bcd_digit_dn: one decade down-digit. It has Clk, Reset, Load, LoadVal[3:0], En, Clr, and outputs Q[3:0] and Zero (Q=0).
  - It is instantiated twice.
  - The units En is the decrement strobe.
  - The tens En is the decrement strobe ANDed with units Zero.
- The FSM and output decode live in ctrl_rega. All outputs are registered or decoded from state only, and carry no combinational path from inputs.

## Test plan
- Reset, then Start with Mode=0 and 50 Ticks → Valve high from cycle 2, count 50→49…→00, Done pulses once, Busy low afterwards.
- Mode=1 with Tick applied at count 10 → count becomes 09; a further 9 Ticks → 00 and then DONE.
- In RUN at count 27, set Hold=1 with Tick=1 in the same cycle → PAUSE, count stays 27, Valve=0. Ticks during PAUSE are ignored. Hold=0 → RUN, Valve=1.
- Abort in RUN at count 13 → IDLE next cycle, Tens/Units=00, Done stays 0. A Start while Busy is ignored.
- PRE_A=8'h00 with Start → LOAD→DONE, Valve never high, Done pulses once.
- Reset asserted in PAUSE at count 41 → all outputs 0 next cycle, IDLE; a subsequent Start runs normally.

Source files
------------

// File: rtl/ctrl_rega_pkg.sv
// Shared types and constants for the irrigation zone watering controller.
package ctrl_rega_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned COUNT_W = 2 * DIGIT_W;

  localparam logic [COUNT_W-1:0] PRE_A_DEF = 8'h50;
  localparam logic [COUNT_W-1:0] PRE_B_DEF = 8'h30;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] units;
  } bcd_count_t;

  // Preset chosen by the captured mode: 0 = drip, 1 = sprinkler.
  function automatic bcd_count_t preset_sel(input logic mode,
                                            input logic [COUNT_W-1:0] pre_a,
                                            input logic [COUNT_W-1:0] pre_b);
    return mode ? bcd_count_t'(pre_b) : bcd_count_t'(pre_a);
  endfunction

endpackage

// File: rtl/ctrl_rega_if.sv
// Operator/sensor inputs and valve/display outputs of one watering zone.
interface ctrl_rega_if;
  import ctrl_rega_pkg::*;

  logic               Start;
  logic               Mode;
  logic               Tick;
  logic               Hold;
  logic               Abort;
  logic               Valve;
  logic               Busy;
  logic               Paused;
  logic               Done;
  logic [DIGIT_W-1:0] Tens;
  logic [DIGIT_W-1:0] Units;

  modport master (
    output Start, Mode, Tick, Hold, Abort,
    input  Valve, Busy, Paused, Done, Tens, Units
  );

  modport slave (
    input  Start, Mode, Tick, Hold, Abort,
    output Valve, Busy, Paused, Done, Tens, Units
  );
endinterface

// File: rtl/ctrl_rega_bcd_digit_dn.sv
// One BCD decade of the remaining-time down-counter.
module bcd_digit_dn
  import ctrl_rega_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Load,
  input  logic [DIGIT_W-1:0] LoadVal,
  input  logic               En,
  input  logic               Clr,
  output logic [DIGIT_W-1:0] Q,
  output logic               Zero
);

  // Clear beats load beats decrement; 0 borrows to 9.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Q <= '0;
    end else if (Clr) begin
      Q <= '0;
    end else if (Load) begin
      Q <= LoadVal;
    end else if (En) begin
      Q <= Zero ? DIGIT_MAX : Q - DIGIT_W'(1);
    end
  end

  // Digit-at-zero flag feeds the next decade's borrow and terminal count.
  assign Zero = (Q == '0);

endmodule

// File: rtl/ctrl_rega.sv
// Watering timer sequencer: preset, minute countdown, pause/abort, valve drive.
module ctrl_rega
  import ctrl_rega_pkg::*;
#(
  parameter logic [COUNT_W-1:0] PRE_A = PRE_A_DEF,
  parameter logic [COUNT_W-1:0] PRE_B = PRE_B_DEF
) (
  input  logic          Clk,
  input  logic          Reset,
  ctrl_rega_if.slave    bus
);

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic               load_c, clr_c, dec_c;
  logic               units_zero, tens_zero, count_zero;
  logic [DIGIT_W-1:0] tens_q, units_q;
  bcd_count_t         preset;

  assign preset     = preset_sel(mode_q, PRE_A, PRE_B);
  assign count_zero = units_zero & tens_zero;

  // State and captured mode registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // Next state and counter controls; Abort > terminal count > Hold > Tick.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    load_c  = 1'b0;
    clr_c   = 1'b0;
    dec_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          mode_d  = bus.Mode;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.Abort) begin
          clr_c   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          load_c  = 1'b1;
          state_d = (preset == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.Abort) begin
          clr_c   = 1'b1;
          state_d = ST_IDLE;
        end else if (count_zero) begin
          state_d = ST_DONE;
        end else if (bus.Hold) begin
          state_d = ST_PAUSE;
        end else if (bus.Tick) begin
          dec_c = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (bus.Abort) begin
          clr_c   = 1'b1;
          state_d = ST_IDLE;
        end else if (!bus.Hold) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  bcd_digit_dn u_units (
    .Clk     (Clk),
    .Reset   (Reset),
    .Load    (load_c),
    .LoadVal (preset.units),
    .En      (dec_c),
    .Clr     (clr_c),
    .Q       (units_q),
    .Zero    (units_zero)
  );

  bcd_digit_dn u_tens (
    .Clk     (Clk),
    .Reset   (Reset),
    .Load    (load_c),
    .LoadVal (preset.tens),
    .En      (dec_c & units_zero),
    .Clr     (clr_c),
    .Q       (tens_q),
    .Zero    (tens_zero)
  );

  // Outputs decoded from the state register and counter registers only.
  assign bus.Valve  = (state_q == ST_RUN);
  assign bus.Busy   = (state_q != ST_IDLE);
  assign bus.Paused = (state_q == ST_PAUSE);
  assign bus.Done   = (state_q == ST_DONE);
  assign bus.Tens   = tens_q;
  assign bus.Units  = units_q;

endmodule

// File: tb/tb_ctrl_rega.sv
// Self-checking bench for ctrl_rega: vector table plus multi-cycle sequences.
module tb_ctrl_rega;

  typedef struct packed {
    logic rst, start, mode, tick, hold, abort;
  } stim_t;

  typedef struct packed {
    logic       valve, busy, paused, done;
    logic [3:0] tens, units;
  } obs_t;

  typedef struct {
    stim_t s;
    obs_t  e;
    string nm;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  int checks = 0;
  int errors = 0;

  obs_t  exp_q[$];
  string nm_q[$];

  ctrl_rega_if ifa ();
  ctrl_rega_if ifb ();

  ctrl_rega #(.PRE_A(8'h50), .PRE_B(8'h30)) dut_a (
    .Clk   (clk),
    .Reset (rst_a),
    .bus   (ifa.slave)
  );

  ctrl_rega #(.PRE_A(8'h00), .PRE_B(8'h30)) dut_b (
    .Clk   (clk),
    .Reset (rst_b),
    .bus   (ifb.slave)
  );

  always #5 clk = ~clk;

  function automatic stim_t st(bit rst, bit start, bit mode, bit tick, bit hold, bit abort);
    stim_t s;
    s = '{rst: rst, start: start, mode: mode, tick: tick, hold: hold, abort: abort};
    return s;
  endfunction

  function automatic obs_t ob(bit v, bit b, bit p, bit d, int cnt);
    obs_t o;
    o = '{valve: v, busy: b, paused: p, done: d,
          tens: 4'(cnt / 10), units: 4'(cnt % 10)};
    return o;
  endfunction

  function automatic obs_t o_idle();      return ob(0, 0, 0, 0, 0); endfunction
  function automatic obs_t o_load();      return ob(0, 1, 0, 0, 0); endfunction
  function automatic obs_t o_done();      return ob(0, 1, 0, 1, 0); endfunction
  function automatic obs_t o_run(int c);   return ob(1, 1, 0, 0, c); endfunction
  function automatic obs_t o_pause(int c); return ob(0, 1, 1, 0, c); endfunction

  // Drive one cycle of stimulus, queue its expectation, check after the edge.
  task automatic cycle(input bit use_b, input stim_t s, input obs_t e, input string nm);
    obs_t  act, want;
    string wnm;
    if (use_b) begin
      rst_b = s.rst; ifb.Start = s.start; ifb.Mode = s.mode;
      ifb.Tick = s.tick; ifb.Hold = s.hold; ifb.Abort = s.abort;
    end else begin
      rst_a = s.rst; ifa.Start = s.start; ifa.Mode = s.mode;
      ifa.Tick = s.tick; ifa.Hold = s.hold; ifa.Abort = s.abort;
    end
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
    if (use_b)
      act = '{valve: ifb.Valve, busy: ifb.Busy, paused: ifb.Paused, done: ifb.Done,
              tens: ifb.Tens, units: ifb.Units};
    else
      act = '{valve: ifa.Valve, busy: ifa.Busy, paused: ifa.Paused, done: ifa.Done,
              tens: ifa.Tens, units: ifa.Units};
    want = exp_q.pop_front();
    wnm  = nm_q.pop_front();
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got v%0b b%0b p%0b d%0b %0h%0h, expected v%0b b%0b p%0b d%0b %0h%0h",
               wnm, act.valve, act.busy, act.paused, act.done, act.tens, act.units,
               want.valve, want.busy, want.paused, want.done, want.tens, want.units);
    end
  endtask

  vec_t tbl[16];

  initial begin
    ifa.Start = 0; ifa.Mode = 0; ifa.Tick = 0; ifa.Hold = 0; ifa.Abort = 0;
    ifb.Start = 0; ifb.Mode = 0; ifb.Tick = 0; ifb.Hold = 0; ifb.Abort = 0;

    tbl[0]  = '{st(1,0,0,0,0,0), o_idle(),     "reset"};
    tbl[1]  = '{st(0,0,0,1,1,1), o_idle(),     "idle_ignores"};
    tbl[2]  = '{st(0,1,0,0,0,0), o_load(),     "start_m0_load"};
    tbl[3]  = '{st(0,0,0,0,0,0), o_run(50),    "run_preset_a"};
    tbl[4]  = '{st(0,0,0,1,0,0), o_run(49),    "first_tick"};
    tbl[5]  = '{st(0,0,0,1,1,0), o_pause(49),  "hold_over_tick"};
    tbl[6]  = '{st(0,0,0,1,1,0), o_pause(49),  "pause_ignores_tick"};
    tbl[7]  = '{st(0,0,0,1,0,0), o_run(49),    "resume"};
    tbl[8]  = '{st(0,1,1,0,0,0), o_run(49),    "start_busy_ignored"};
    tbl[9]  = '{st(0,0,0,1,0,1), o_idle(),     "abort_run"};
    tbl[10] = '{st(0,1,1,1,0,0), o_load(),     "start_m1_load"};
    tbl[11] = '{st(0,0,0,1,0,0), o_run(30),    "load_drops_tick"};
    tbl[12] = '{st(0,0,0,1,0,0), o_run(29),    "units_borrow"};
    tbl[13] = '{st(1,0,0,1,0,0), o_idle(),     "reset_run"};
    tbl[14] = '{st(0,1,0,0,0,0), o_load(),     "start_again"};
    tbl[15] = '{st(0,0,0,0,0,1), o_idle(),     "abort_load"};

    for (int i = 0; i < 16; i++) cycle(0, tbl[i].s, tbl[i].e, tbl[i].nm);

    // Mode 0 full countdown, ticks on alternate cycles.
    cycle(0, st(0,1,0,0,0,0), o_load(), "a_load");
    cycle(0, st(0,0,0,0,0,0), o_run(50), "a_run50");
    for (int c = 49; c >= 1; c--) begin
      cycle(0, st(0,0,0,1,0,0), o_run(c), "a_tick");
      cycle(0, st(0,0,0,0,0,0), o_run(c), "a_gap");
    end
    cycle(0, st(0,0,0,1,0,0), o_run(0), "a_reach00");
    cycle(0, st(0,0,0,1,0,0), o_done(), "a_done_no_wrap");
    cycle(0, st(0,0,0,0,0,0), o_idle(), "a_idle_after");
    cycle(0, st(0,0,0,0,0,0), o_idle(), "a_done_once");

    // Mode 1: tens borrow at 10 -> 09, then finish.
    cycle(0, st(0,1,1,0,0,0), o_load(), "b_load");
    cycle(0, st(0,0,0,0,0,0), o_run(30), "b_run30");
    for (int c = 29; c >= 10; c--) cycle(0, st(0,0,0,1,0,0), o_run(c), "b_tick");
    cycle(0, st(0,0,0,1,0,0), o_run(9), "b_10_to_09");
    for (int c = 8; c >= 0; c--) cycle(0, st(0,0,0,1,0,0), o_run(c), "b_tail");
    cycle(0, st(0,0,0,0,0,0), o_done(), "b_done");
    cycle(0, st(0,0,0,0,0,0), o_idle(), "b_idle");

    // Hold at 27 with coincident tick, then abort at 13.
    cycle(0, st(0,1,1,0,0,0), o_load(), "c_load");
    cycle(0, st(0,0,0,0,0,0), o_run(30), "c_run30");
    for (int c = 29; c >= 27; c--) cycle(0, st(0,0,0,1,0,0), o_run(c), "c_tick");
    cycle(0, st(0,0,0,1,1,0), o_pause(27), "c_hold27");
    for (int k = 0; k < 3; k++) cycle(0, st(0,0,0,1,1,0), o_pause(27), "c_pause_tick");
    cycle(0, st(0,0,0,1,0,0), o_run(27), "c_release");
    for (int c = 26; c >= 13; c--) cycle(0, st(0,0,0,1,0,0), o_run(c), "c_tick2");
    cycle(0, st(0,0,0,1,0,1), o_idle(), "c_abort13");
    cycle(0, st(0,0,0,0,0,0), o_idle(), "c_no_done");

    // Reset while paused at 41, then a normal restart.
    cycle(0, st(0,1,0,0,0,0), o_load(), "d_load");
    cycle(0, st(0,0,0,0,0,0), o_run(50), "d_run50");
    for (int c = 49; c >= 41; c--) cycle(0, st(0,0,0,1,0,0), o_run(c), "d_tick");
    cycle(0, st(0,0,0,0,1,0), o_pause(41), "d_pause41");
    cycle(0, st(1,0,0,0,1,0), o_idle(), "d_reset_pause");
    cycle(0, st(0,1,0,0,0,0), o_load(), "d_restart_load");
    cycle(0, st(0,0,0,0,0,0), o_run(50), "d_restart_run");
    cycle(0, st(0,0,0,1,0,0), o_run(49), "d_restart_tick");
    cycle(0, st(0,0,0,0,0,1), o_idle(), "d_abort");

    // Zero preset: LOAD straight to DONE, valve never opens.
    cycle(1, st(1,0,0,0,0,0), o_idle(), "e_reset");
    cycle(1, st(0,1,0,1,0,0), o_load(), "e_load");
    cycle(1, st(0,0,0,1,0,0), o_done(), "e_done_zero");
    cycle(1, st(0,0,0,0,0,1), o_idle(), "e_idle");
    cycle(1, st(0,0,0,0,0,0), o_idle(), "e_done_once");
    cycle(1, st(0,1,1,0,0,0), o_load(), "e_load_b");
    cycle(1, st(0,0,0,0,0,0), o_run(30), "e_run30");
    cycle(1, st(0,0,0,0,0,1), o_idle(), "e_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
